// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported RAM between the instruction-fetch and data requesters.
// Define MEM_ARB_RR_EN to switch from fixed data priority to round-robin arbitration.
module mem_port_arbiter #(
  parameter int RAM_LAT = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          iREN,
  input  logic [AW-1:0] iaddr,
  input  logic          dREN,
  input  logic          dWEN,
  input  logic [AW-1:0] daddr,
  input  logic [DW-1:0] dstore,
  input  logic [DW-1:0] ramload,
  output logic          ihit,
  output logic          dhit,
  output logic [DW-1:0] iload,
  output logic [DW-1:0] dload,
  output logic          ramREN,
  output logic          ramWEN,
  output logic [AW-1:0] ramaddr,
  output logic [DW-1:0] ramstore,
  output logic          busy
);

  localparam int CW = $clog2(RAM_LAT + 1);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_nextCount;
  logic            r_ownerD;
  logic            r_write;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_store;
  logic [DW-1:0]   r_iload;
  logic [DW-1:0]   r_dload;
  logic            w_dReq;
  logic            w_grant;
  logic            w_grantD;

  assign w_dReq  = dREN | dWEN;
  assign w_grant = w_dReq | iREN;

`ifdef MEM_ARB_RR_EN
  logic r_lastOwnerD;

  // On contention the requester that lost the previous grant goes first.
  assign w_grantD = w_dReq & (~iREN | ~r_lastOwnerD);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_lastOwnerD <= 1'b0;
    end else if (r_state == IDLE && w_grant) begin
      r_lastOwnerD <= w_grantD;
    end
  end
`else
  assign w_grantD = w_dReq;
`endif

  assign iload = r_iload;
  assign dload = r_dload;

  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_count;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    ihit        = 1'b0;
    dhit        = 1'b0;
    busy        = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (w_grant) begin
          w_nextState = ACC;
          w_nextCount = CW'(RAM_LAT - 1);
        end
      end
      ACC: begin
        ramREN   = ~r_write;
        ramWEN   = r_write;
        ramaddr  = r_addr;
        ramstore = r_store;
        if (r_count == '0) begin
          w_nextState = DONE;
        end else begin
          w_nextCount = r_count - CW'(1);
        end
      end
      DONE: begin
        // A requester that dropped its request (flush) gets no completion strobe.
        ihit        = ~r_ownerD & iREN;
        dhit        = r_ownerD & w_dReq;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_ownerD <= 1'b0;
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_store  <= '0;
      r_iload  <= '0;
      r_dload  <= '0;
    end else begin
      r_state <= w_nextState;
      r_count <= w_nextCount;
      if (r_state == IDLE && w_grant) begin
        r_ownerD <= w_grantD;
        r_write  <= w_grantD & dWEN;
        r_addr   <= w_grantD ? daddr : iaddr;
        r_store  <= w_grantD ? dstore : '0;
      end
      // Read data is captured even for a flushed access.
      if (r_state == ACC && r_count == '0 && !r_write) begin
        if (r_ownerD) begin
          r_dload <= ramload;
        end else begin
          r_iload <= ramload;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: a transaction-level model predicts
// RAM accesses and hit strobes by cycle; a monitor compares them as the DUT presents them.
module tb_mem_port_arbiter;

  localparam int L = 2;

  logic        CLK;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] ramload;
  logic        ihit;
  logic        dhit;
  logic [31:0] iload;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic        busy;

  typedef struct {
    int          cyc;
    bit          isData;
    logic [31:0] load;
  } hitExp_t;

  typedef struct {
    int          cyc;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] store;
  } ramExp_t;

  hitExp_t     hitQ[$];
  ramExp_t     ramQ[$];
  hitExp_t     he;
  ramExp_t     re;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [31:0] mIload = '0;
  logic [31:0] mDload = '0;
  bit          mLastD = 1'b0;

  mem_port_arbiter #(.RAM_LAT(L), .AW(32), .DW(32)) dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .ramload(ramload), .ihit(ihit), .dhit(dhit),
    .iload(iload), .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .busy(busy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural RAM contents: each address holds a distinct word.
  function automatic logic [31:0] memFn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h2008_0001 ^ {a[7:0], 24'h0};
  endfunction

  assign ramload = memFn(ramaddr);

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge CLK) begin
    checkOutput("hit_exclusive", ihit & dhit, 0);
    checkOutput("ram_en_exclusive", ramREN & ramWEN, 0);
    if (ihit || dhit) begin
      if (hitQ.size() == 0) begin
        checkOutput("unexpected_hit", {ihit, dhit}, 0);
      end else begin
        he = hitQ.pop_front();
        checkOutput("hit_cycle", cyc, he.cyc);
        checkOutput("hit_port", dhit, he.isData);
        checkOutput("hit_load", dhit ? dload : iload, he.load);
      end
    end
    if (ramREN || ramWEN) begin
      if (ramQ.size() == 0) begin
        checkOutput("unexpected_ram", {ramREN, ramWEN}, 0);
      end else begin
        re = ramQ.pop_front();
        checkOutput("ram_cycle", cyc, re.cyc);
        checkOutput("ram_write", ramWEN, re.wr);
        checkOutput("ram_addr", ramaddr, re.addr);
        if (re.wr) checkOutput("ram_store", ramstore, re.store);
      end
    end
  end

  // Transaction-level prediction of one granted access starting in IDLE cycle t.
  task automatic modelGrant(input int t, input bit isData, input bit wr,
                            input logic [31:0] a, input logic [31:0] s, input bit hitExp);
    for (int k = 1; k <= L; k++) ramQ.push_back('{t + k, wr, a, s});
    if (!wr) begin
      if (isData) mDload = memFn(a);
      else mIload = memFn(a);
    end
    if (hitExp) hitQ.push_back('{t + L + 1, isData, isData ? mDload : mIload});
    mLastD = isData;
  endtask

  task automatic nextCycle(input bit scI, input bit scD);
    @(posedge CLK);
    #1;
    if (scI) iaddr = $urandom;
    if (scD) begin
      daddr  = $urandom;
      dstore = $urandom;
    end
  endtask

  task automatic dropAll();
    iREN = 1'b0;
    dREN = 1'b0;
    dWEN = 1'b0;
  endtask

  task automatic raise(input bit isData, input bit wr, input logic [31:0] a, input logic [31:0] s);
    if (isData) begin
      daddr  = a;
      dstore = s;
      dWEN   = wr;
      dREN   = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    end else begin
      iaddr = a;
      iREN  = 1'b1;
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_ihit"}, ihit, 0);
    checkOutput({tag, "_dhit"}, dhit, 0);
    checkOutput({tag, "_ramREN"}, ramREN, 0);
    checkOutput({tag, "_ramWEN"}, ramWEN, 0);
    checkOutput({tag, "_ramaddr"}, ramaddr, 0);
    checkOutput({tag, "_ramstore"}, ramstore, 0);
    checkOutput({tag, "_iload"}, iload, 0);
    checkOutput({tag, "_dload"}, dload, 0);
  endtask

  task automatic applyStimulus(input int kind);
    int          t;
    int          m;
    bit          isData;
    bit          wr;
    bit          firstD;
    logic [31:0] a;
    logic [31:0] s;
    logic [31:0] ai;
    t      = cyc;
    a      = $urandom;
    s      = $urandom;
    isData = (kind == 1 || kind == 2) ? 1'b1 : (kind == 0 ? 1'b0 : 1'($urandom_range(0, 1)));
    wr     = (kind == 2) ? 1'b1 : (isData && kind >= 3 ? 1'($urandom_range(0, 1)) : 1'b0);
    case (kind)
      0, 1, 2: begin
        raise(isData, wr, a, s);
        modelGrant(t, isData, wr, a, s, 1'b1);
        repeat (L + 1) nextCycle(!isData, isData);
        nextCycle(1'b0, 1'b0);
        dropAll();
      end
      3: begin
        ai = $urandom;
        wr = 1'($urandom_range(0, 1));
        raise(1'b1, wr, a, s);
        raise(1'b0, 1'b0, ai, '0);
`ifdef MEM_ARB_RR_EN
        firstD = !mLastD;
`else
        firstD = 1'b1;
`endif
        if (firstD) begin
          modelGrant(t, 1'b1, wr, a, s, 1'b1);
          modelGrant(t + L + 2, 1'b0, 1'b0, ai, '0, 1'b1);
        end else begin
          modelGrant(t, 1'b0, 1'b0, ai, '0, 1'b1);
          modelGrant(t + L + 2, 1'b1, wr, a, s, 1'b1);
        end
        repeat (L + 1) nextCycle(!firstD, firstD);
        nextCycle(1'b0, 1'b0);
        if (firstD) begin
          dREN = 1'b0;
          dWEN = 1'b0;
        end else begin
          iREN = 1'b0;
        end
        repeat (L + 1) nextCycle(firstD, !firstD);
        nextCycle(1'b0, 1'b0);
        dropAll();
      end
      4: begin
        m = $urandom_range(1, L);
        raise(isData, wr, a, s);
        modelGrant(t, isData, wr, a, s, 1'b0);
        for (int k = 1; k <= m; k++) nextCycle(!isData, isData);
        dropAll();
        repeat (L + 2 - m) nextCycle(1'b0, 1'b0);
        checkOutput("flush_busy_after_done", busy, 0);
        checkOutput("flush_iload", iload, mIload);
        checkOutput("flush_dload", dload, mDload);
      end
      default: begin
        raise(isData, wr, a, s);
        ramQ.push_back('{t + 1, wr, a, s});
        mIload = '0;
        mDload = '0;
        mLastD = 1'b0;
        nextCycle(1'b0, 1'b0);
        RST = 1'b1;
        dropAll();
        nextCycle(1'b0, 1'b0);
        RST = 1'b0;
        checkAllZero("reset_mid_acc");
      end
    endcase
    checkOutput("iload_model", iload, mIload);
    checkOutput("dload_model", dload, mDload);
  endtask

  initial begin
    RST    = 1'b1;
    iREN   = 1'b0;
    dREN   = 1'b0;
    dWEN   = 1'b0;
    iaddr  = '0;
    daddr  = '0;
    dstore = '0;
    repeat (3) nextCycle(1'b0, 1'b0);
    checkAllZero("reset");
    RST = 1'b0;
    for (int n = 0; n < 200; n++) begin
      applyStimulus($urandom_range(0, 5));
      repeat ($urandom_range(0, 2)) nextCycle(1'b0, 1'b0);
    end
    repeat (L + 4) nextCycle(1'b0, 1'b0);
    checkOutput("hit_queue_drained", hitQ.size(), 0);
    checkOutput("ram_queue_drained", ramQ.size(), 0);
    checkOutput("idle_at_end", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
